// File: rtl/stereo_mux_scheduler_pkg.sv
// Shared stereo-stage definitions: channel encoding, slot FSM states, sample width.
package stereo_mux_scheduler_pkg;

   localparam int SAMPLE_W = 10;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/stereo_mux_scheduler_if.sv
// Left/right sample sources, output slot and status signals of the stereo mux scheduler.
interface stereo_mux_scheduler_if #(
   parameter int WIDTH = stereo_mux_scheduler_pkg::SAMPLE_W
);
   logic             l_valid;
   logic [WIDTH-1:0] l_data;
   logic             l_ready;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             r_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_chan;
   logic             out_ready;
   logic             err_timeout;
   logic [7:0]       skip_count;

   // master: sources and downstream consumer; slave: the scheduler
   modport master (
      output l_valid, l_data, input l_ready,
      output r_valid, r_data, input r_ready,
      input  out_valid, out_data, out_chan,
      output out_ready,
      input  err_timeout, skip_count
   );

   modport slave (
      input  l_valid, l_data, output l_ready,
      input  r_valid, r_data, output r_ready,
      output out_valid, out_data, out_chan,
      input  out_ready,
      output err_timeout, skip_count
   );
endinterface

// File: rtl/multiplexer_2_10bit.sv
// Shared 2:1 sample selector: i_sel=0 picks i_a (left), i_sel=1 picks i_b (right).
module multiplexer_2_10bit
   import stereo_mux_scheduler_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W
) (
   input  logic             i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign o_y[gi] = (i_sel == CH_R) ? i_b[gi] : i_a[gi];
      end
   endgenerate

endmodule

// File: rtl/stereo_mux_scheduler.sv
// Arbitrates left/right sample sources into a single-entry output slot, with strict
// L/R interleave (timeout skip of a stalled channel) or round-robin arbitration.
module stereo_mux_scheduler
   import stereo_mux_scheduler_pkg::*;
#(
   parameter int WIDTH      = SAMPLE_W,
   parameter int STRICT_ALT = 1,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   stereo_mux_scheduler_if.slave  bus
);

   localparam logic [8:0] LP_TIMEOUT = 9'(TIMEOUT);

   state_t           r_state;
   state_t           w_state_next;
   logic             r_expect;
   logic             r_last;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_chan;
   logic             r_err;
   logic [7:0]       r_skip;

   logic             w_slot_free;
   logic             w_grant_l;
   logic             w_grant_r;
   logic             w_accept;
   logic             w_sel;
   logic             w_exp_valid;
   logic             w_oth_valid;
   logic             w_cnt_inc;
   logic             w_hit;
   logic [WIDTH-1:0] w_mux;

   assign w_slot_free = (r_state == ST_EMPTY) | bus.out_ready;

   always_comb begin
      w_grant_l   = 1'b0;
      w_grant_r   = 1'b0;
      w_exp_valid = 1'b0;
      w_oth_valid = 1'b0;
      w_cnt_inc   = 1'b0;
      if (STRICT_ALT != 0) begin
         w_grant_l   = w_slot_free & bus.l_valid & (r_expect == CH_L);
         w_grant_r   = w_slot_free & bus.r_valid & (r_expect == CH_R);
         w_exp_valid = (r_expect == CH_L) ? bus.l_valid : bus.r_valid;
         w_oth_valid = (r_expect == CH_L) ? bus.r_valid : bus.l_valid;
         w_cnt_inc   = w_slot_free & ~w_exp_valid & w_oth_valid;
      end else if (w_slot_free) begin
         if (bus.l_valid && bus.r_valid) begin
            w_grant_l = (r_last == CH_R);
            w_grant_r = (r_last == CH_L);
         end else begin
            w_grant_l = bus.l_valid;
            w_grant_r = bus.r_valid;
         end
      end
   end

   // A timeout cycle never grants: the expected channel is by definition not valid
   assign w_hit    = w_cnt_inc & (({1'b0, r_cnt} + 9'd1) == LP_TIMEOUT);
   assign w_accept = w_grant_l | w_grant_r;

   always_comb begin
      w_sel = (STRICT_ALT != 0) ? r_expect : r_last;
      if (w_grant_r)
         w_sel = CH_R;
      else if (w_grant_l)
         w_sel = CH_L;
   end

   multiplexer_2_10bit #(.WIDTH(WIDTH)) u_sample_mux (
      .i_sel (w_sel),
      .i_a   (bus.l_data),
      .i_b   (bus.r_data),
      .o_y   (w_mux)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= ST_EMPTY;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
         ST_FULL:  if (!w_accept && bus.out_ready) w_state_next = ST_EMPTY;
         default:  w_state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_expect   <= CH_L;
         r_last     <= CH_R;
         r_cnt      <= 8'd0;
         r_out_data <= '0;
         r_out_chan <= CH_L;
         r_err      <= 1'b0;
         r_skip     <= 8'd0;
      end else begin
         r_err <= w_hit;
         if (w_accept) begin
            r_out_data <= w_mux;
            r_out_chan <= w_sel;
            r_expect   <= ~r_expect;
            r_last     <= w_sel;
            r_cnt      <= 8'd0;
         end else if (w_hit) begin
            r_expect <= ~r_expect;
            r_cnt    <= 8'd0;
            if (r_skip != 8'hFF)
               r_skip <= r_skip + 8'd1;
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign bus.l_ready     = w_grant_l;
   assign bus.r_ready     = w_grant_r;
   assign bus.out_valid   = (r_state == ST_FULL);
   assign bus.out_data    = r_out_data;
   assign bus.out_chan    = r_out_chan;
   assign bus.err_timeout = r_err;
   assign bus.skip_count  = r_skip;

endmodule

// File: tb/tb_stereo_mux_scheduler.sv
// Directed bench: strict-mode instance (TIMEOUT=4) and round-robin instance share clk/reset.
module tb_stereo_mux_scheduler;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   stereo_mux_scheduler_if #(.WIDTH(10)) ifs ();
   stereo_mux_scheduler_if #(.WIDTH(10)) ifr ();

   stereo_mux_scheduler #(.WIDTH(10), .STRICT_ALT(1), .TIMEOUT(4)) u_strict (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs.slave)
   );

   stereo_mux_scheduler #(.WIDTH(10), .STRICT_ALT(0), .TIMEOUT(4)) u_rr (
      .clk   (clk),
      .reset (reset),
      .bus   (ifr.slave)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      ifs.l_valid = 0; ifs.r_valid = 0; ifs.l_data = '0; ifs.r_data = '0; ifs.out_ready = 0;
      ifr.l_valid = 0; ifr.r_valid = 0; ifr.l_data = '0; ifr.r_data = '0; ifr.out_ready = 0;
      step();
      step();

      // Reset state
      chk("rst_out_valid", 32'(ifs.out_valid), 0);
      chk("rst_out_data", 32'(ifs.out_data), 0);
      chk("rst_out_chan", 32'(ifs.out_chan), 0);
      chk("rst_err", 32'(ifs.err_timeout), 0);
      chk("rst_skip", 32'(ifs.skip_count), 0);
      chk("rst_l_ready", 32'(ifs.l_ready), 0);
      chk("rst_r_ready", 32'(ifs.r_ready), 0);
      reset = 1'b0;
      step();

      // Strict interleave
      ifs.l_valid = 1; ifs.r_valid = 1;
      ifs.l_data = 10'h155; ifs.r_data = 10'h2AA; ifs.out_ready = 1;
      #1;
      chk("first_out_valid_pre", 32'(ifs.out_valid), 0);
      for (int i = 0; i < 6; i++) begin
         chk("il_l_ready", 32'(ifs.l_ready), 32'(i % 2 == 0));
         chk("il_r_ready", 32'(ifs.r_ready), 32'(i % 2 == 1));
         step();
         chk("il_out_valid", 32'(ifs.out_valid), 1);
         chk("il_out_data", 32'(ifs.out_data), (i % 2 == 0) ? 32'h155 : 32'h2AA);
         chk("il_out_chan", 32'(ifs.out_chan), 32'(i % 2));
      end

      // Backpressure: slot holds 0x2AA/ch1, expect=L
      ifs.out_ready = 0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_l_ready", 32'(ifs.l_ready), 0);
         chk("bp_r_ready", 32'(ifs.r_ready), 0);
         step();
         chk("bp_out_valid", 32'(ifs.out_valid), 1);
         chk("bp_out_data", 32'(ifs.out_data), 32'h2AA);
         chk("bp_out_chan", 32'(ifs.out_chan), 1);
      end
      ifs.out_ready = 1;
      #1;
      chk("bp_release_l_ready", 32'(ifs.l_ready), 1);
      step();
      chk("bp_release_data", 32'(ifs.out_data), 32'h155);
      chk("bp_release_chan", 32'(ifs.out_chan), 0);
      chk("bp_release_valid", 32'(ifs.out_valid), 1);

      // Consume one right sample so that expect=L, then starve left
      ifs.l_valid = 0;
      #1;
      chk("to_setup_r_ready", 32'(ifs.r_ready), 1);
      step();
      chk("to_setup_data", 32'(ifs.out_data), 32'h2AA);
      for (int k = 1; k <= 4; k++) begin
         chk("to_r_ready_blocked", 32'(ifs.r_ready), 0);
         chk("to_l_ready_blocked", 32'(ifs.l_ready), 0);
         step();
         chk("to_err", 32'(ifs.err_timeout), 32'(k == 4));
      end
      chk("to_skip", 32'(ifs.skip_count), 1);
      chk("to_r_ready_after", 32'(ifs.r_ready), 1);
      step();
      chk("to_grant_data", 32'(ifs.out_data), 32'h2AA);
      chk("to_grant_chan", 32'(ifs.out_chan), 1);
      chk("to_grant_valid", 32'(ifs.out_valid), 1);
      chk("to_err_cleared", 32'(ifs.err_timeout), 0);

      // Saturation: each further skip costs 5 cycles, 1600 cycles exceed 300 skips
      repeat (1600) step();
      chk("sat_skip", 32'(ifs.skip_count), 255);

      // Reset while FULL
      ifs.out_ready = 0;
      for (int n = 0; n < 10 && !ifs.out_valid; n++) step();
      chk("full_before_reset", 32'(ifs.out_valid), 1);
      reset = 1'b1;
      #1;
      chk("arst_out_valid", 32'(ifs.out_valid), 0);
      chk("arst_out_data", 32'(ifs.out_data), 0);
      chk("arst_out_chan", 32'(ifs.out_chan), 0);
      chk("arst_skip", 32'(ifs.skip_count), 0);
      chk("arst_err", 32'(ifs.err_timeout), 0);
      chk("arst_l_ready", 32'(ifs.l_ready), 0);
      chk("arst_r_ready", 32'(ifs.r_ready), 0);
      step();
      ifs.r_valid = 0;
      reset = 1'b0;
      step();

      // Round-robin: left only, then both valid
      ifr.l_valid = 1; ifr.l_data = 10'h001; ifr.r_data = 10'h3FF; ifr.out_ready = 1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rr_lonly_l_ready", 32'(ifr.l_ready), 1);
         chk("rr_lonly_r_ready", 32'(ifr.r_ready), 0);
         step();
         chk("rr_lonly_data", 32'(ifr.out_data), 32'h001);
         chk("rr_lonly_chan", 32'(ifr.out_chan), 0);
      end
      ifr.r_valid = 1;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_both_r_ready", 32'(ifr.r_ready), 32'(i % 2 == 0));
         chk("rr_both_l_ready", 32'(ifr.l_ready), 32'(i % 2 == 1));
         step();
         chk("rr_both_data", 32'(ifr.out_data), (i % 2 == 0) ? 32'h3FF : 32'h001);
         chk("rr_both_chan", 32'(ifr.out_chan), 32'(i % 2 == 0));
      end
      ifr.l_valid = 0;
      repeat (10) step();
      chk("rr_err", 32'(ifr.err_timeout), 0);
      chk("rr_skip", 32'(ifr.skip_count), 0);
      ifr.r_valid = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
